// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over WIDTH cycles, with a start/ready handshake and a one-cycle done pulse.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             kill,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    COUNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MIN_NEG    = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_reg, state_next;
  muldiv_funct3_t   funct3_reg, funct3_next;
  logic             neg_a_reg, neg_a_next;
  logic             neg_b_reg, neg_b_next;
  logic [CW-1:0]    count_reg, count_next;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV.
  logic [WIDTH-1:0] operand_reg, operand_next;
  logic [WIDTH-1:0] result_reg, result_next;

  // Accept-cycle operand decode
  muldiv_funct3_t   f3_in;
  logic             signed_a, signed_b;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_by_zero, div_overflow;

  assign f3_in    = muldiv_funct3_t'(funct3);
  assign signed_a = (f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
                    (f3_in == F3_DIV)  || (f3_in == F3_REM);
  assign signed_b = (f3_in == F3_MULH) || (f3_in == F3_DIV) || (f3_in == F3_REM);
  assign sign_a   = signed_a & rs1_data[WIDTH-1];
  assign sign_b   = signed_b & rs2_data[WIDTH-1];
  assign mag_a    = sign_a ? -rs1_data : rs1_data;
  assign mag_b    = sign_b ? -rs2_data : rs2_data;

  assign div_by_zero  = (rs2_data == '0);
  assign div_overflow = ((f3_in == F3_DIV) || (f3_in == F3_REM)) &&
                        (rs1_data == MIN_NEG) && (rs2_data == '1);

  // One shift-add multiply step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_next;

  assign mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                        (acc_reg[0] ? {1'b0, operand_reg} : '0);
  assign mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // One restoring divide step; the remainder always stays below the divisor,
  // so a WIDTH-bit difference is exact whenever the subtraction is taken.
  logic [WIDTH:0]     rem_shift;
  logic               trial_ge;
  logic [WIDTH-1:0]   trial;
  logic [2*WIDTH-1:0] div_acc_next;

  assign rem_shift    = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign trial_ge     = (rem_shift >= {1'b0, operand_reg});
  assign trial        = rem_shift[WIDTH-1:0] - operand_reg;
  assign div_acc_next = trial_ge ? {trial, acc_reg[WIDTH-2:0], 1'b1}
                                 : {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

  // Sign fix-up and result selection
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;
  logic [WIDTH-1:0]   fix_value;

  assign prod_fixed = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;
  assign quot_fixed = (neg_a_reg ^ neg_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fixed  = neg_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_value = '0;
    unique case (funct3_reg)
      F3_MUL:                       fix_value = prod_fixed[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_value = prod_fixed[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              fix_value = quot_fixed;
      F3_REM, F3_REMU:              fix_value = rem_fixed;
      default:                      fix_value = '0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    funct3_next  = funct3_reg;
    neg_a_next   = neg_a_reg;
    neg_b_next   = neg_b_reg;
    count_next   = count_reg;
    acc_next     = acc_reg;
    operand_next = operand_reg;
    result_next  = result_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (start && !kill) begin
          funct3_next = f3_in;
          neg_a_next  = sign_a;
          neg_b_next  = sign_b;
          count_next  = COUNT_LOAD;
          if (!funct3[2]) begin
            acc_next     = {{WIDTH{1'b0}}, mag_b};
            operand_next = mag_a;
            state_next   = S_MUL;
          end else if (div_by_zero) begin
            result_next = funct3[1] ? rs1_data : '1;
            state_next  = S_DONE;
          end else if (div_overflow) begin
            result_next = funct3[1] ? '0 : MIN_NEG;
            state_next  = S_DONE;
          end else begin
            acc_next     = {{WIDTH{1'b0}}, mag_a};
            operand_next = mag_b;
            state_next   = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (kill) begin
          state_next = S_IDLE;
        end else begin
          acc_next   = mul_acc_next;
          count_next = count_reg - COUNT_ONE;
          if (count_reg == COUNT_ONE) state_next = S_FIX;
        end
      end
      S_DIV: begin
        if (kill) begin
          state_next = S_IDLE;
        end else begin
          acc_next   = div_acc_next;
          count_next = count_reg - COUNT_ONE;
          if (count_reg == COUNT_ONE) state_next = S_FIX;
        end
      end
      S_FIX: begin
        if (kill) begin
          state_next = S_IDLE;
        end else begin
          result_next = fix_value;
          state_next  = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      funct3_reg  <= F3_MUL;
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
      count_reg   <= '0;
      acc_reg     <= '0;
      operand_reg <= '0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      funct3_reg  <= funct3_next;
      neg_a_reg   <= neg_a_next;
      neg_b_reg   <= neg_b_next;
      count_reg   <= count_next;
      acc_reg     <= acc_next;
      operand_reg <= operand_next;
      result_reg  <= result_next;
    end
  end

  assign ready  = (state_reg == S_IDLE);
  assign done   = (state_reg == S_DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: each task applies hand-computed vectors and
// checks results, latency, handshake, kill and asynchronous reset behaviour.
module tb_muldiv_seq;

  localparam int W = 32;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef struct packed {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [2:0]   funct3 = '0;
  logic [W-1:0] rs1 = '0;
  logic [W-1:0] rs2 = '0;
  logic         ready, done;
  logic [W-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1),
    .rs2_data (rs2),
    .kill     (kill),
    .ready    (ready),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Issues one op from IDLE; returns the done cycle (accept edge = cycle 0) or -1.
  // Operands are scrambled after acceptance; poke keeps start high while busy.
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, output int lat, output logic [W-1:0] res);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start  = poke;
      funct3 = 3'($urandom_range(7, 0));
      rs1    = $urandom();
      rs2    = $urandom();
      if (done === 1'b1) begin
        lat = c;
        res = result;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    $display("op f3=%0d a=%h b=%h -> result=%h done_cycle=%0d", f, a, b, res, lat);
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if (result !== '0) begin miscompares++; $display("FAIL reset_result: got %h want 0", result); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    vec_t tbl [9] = '{
      '{F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{F_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
      '{F_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006},
      '{F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{F_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
      '{F_MUL,    32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38},
      '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}
    };
    int lat;
    logic [W-1:0] res;
    foreach (tbl[i]) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, 1'b0, lat, res);
      vectors++;
      if (res !== tbl[i].e) begin
        miscompares++;
        $display("FAIL mul[%0d] result: got %h want %h", i, res, tbl[i].e);
      end
      vectors++;
      if (lat != W + 2) begin
        miscompares++;
        $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, W + 2);
      end
    end
  endtask

  task automatic test_mulhsu_sign();
    // rs1 signed -2^31 times rs2 unsigned 2 gives -2^32; high word all ones
    int lat;
    logic [W-1:0] res;
    run_op(F_MULHSU, 32'h8000_0000, 32'h0000_0002, 1'b0, lat, res);
    vectors++;
    if (res !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL mulhsu_sign result: got %h want ffffffff", res);
    end
    // rs2 with top bit set must be treated as unsigned: 1 * 0x80000000, high word 0
    run_op(F_MULHSU, 32'h0000_0001, 32'h8000_0000, 1'b0, lat, res);
    vectors++;
    if (res !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL mulhsu_unsigned_b result: got %h want 00000000", res);
    end
  endtask

  task automatic test_div();
    vec_t tbl [11] = '{
      '{F_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
      '{F_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
      '{F_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC},
      '{F_REMU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001},
      '{F_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD},
      '{F_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001},
      '{F_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003},
      '{F_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
      '{F_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E},
      '{F_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002},
      '{F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
    };
    int lat;
    logic [W-1:0] res;
    foreach (tbl[i]) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, 1'b0, lat, res);
      vectors++;
      if (res !== tbl[i].e) begin
        miscompares++;
        $display("FAIL div[%0d] result: got %h want %h", i, res, tbl[i].e);
      end
      vectors++;
      if (lat != W + 2) begin
        miscompares++;
        $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, W + 2);
      end
    end
  endtask

  task automatic test_div_special();
    vec_t tbl [7] = '{
      '{F_DIV,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
      '{F_REM,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
      '{F_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
      '{F_REMU, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9},
      '{F_REM,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9},
      '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
    };
    int lat;
    logic [W-1:0] res;
    foreach (tbl[i]) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, 1'b0, lat, res);
      vectors++;
      if (res !== tbl[i].e) begin
        miscompares++;
        $display("FAIL special[%0d] result: got %h want %h", i, res, tbl[i].e);
      end
      vectors++;
      if (lat != 1) begin
        miscompares++;
        $display("FAIL special[%0d] latency: got %0d want 1", i, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] res;
    // start held high while busy must not disturb or queue anything
    run_op(F_MUL, 32'd3, 32'd4, 1'b1, lat, res);
    vectors++;
    if (res !== 32'd12 || lat != W + 2) begin
      miscompares++;
      $display("FAIL busy_start_ignored: got %h at cycle %0d want 0000000c at cycle %0d", res, lat, W + 2);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL after_done: got done=%b ready=%b want done=0 ready=1", done, ready);
    end
    vectors++;
    if (result !== 32'd12) begin
      miscompares++;
      $display("FAIL result_held: got %h want 0000000c", result);
    end
    run_op(F_DIVU, 32'd100, 32'd7, 1'b0, lat, res);
    vectors++;
    if (res !== 32'd14 || lat != W + 2) begin
      miscompares++;
      $display("FAIL second_op: got %h at cycle %0d want 0000000e at cycle %0d", res, lat, W + 2);
    end
  endtask

  task automatic test_kill();
    int seen_done;
    // kill during cycle 10 of a divide
    @(negedge clk);
    funct3 = F_DIV; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk);
    seen_done = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) seen_done++;
      if (c == 10) kill = 1'b1;
    end
    @(negedge clk);
    kill = 1'b0;
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL kill_ready: got %b want 1", ready); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done != 0) begin miscompares++; $display("FAIL kill_no_done: got %0d done pulses want 0", seen_done); end
    vectors++;
    if (result !== 32'd14) begin miscompares++; $display("FAIL kill_result_kept: got %h want 0000000e", result); end
    $display("op kill at cycle 10 of div -> result=%h done_pulses=%0d", result, seen_done);

    // start together with kill in IDLE: a divide-by-zero would otherwise finish next cycle
    @(negedge clk);
    funct3 = F_DIV; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_blocks_start: got ready=%b done=%b want ready=1 done=0", ready, done);
    end
    seen_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done != 0 || result !== 32'd14) begin
      miscompares++;
      $display("FAIL kill_blocks_start_result: got %h with %0d done pulses want 0000000e with 0", result, seen_done);
    end
    $display("op start+kill in idle -> result=%h done_pulses=%0d", result, seen_done);
  endtask

  task automatic test_async_reset();
    int lat;
    logic [W-1:0] res;
    @(negedge clk);
    funct3 = F_MUL; rs1 = 32'd5; rs2 = 32'd5; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_ctrl: got ready=%b done=%b want ready=1 done=0", ready, done);
    end
    vectors++;
    if (result !== '0) begin miscompares++; $display("FAIL async_reset_result: got %h want 0", result); end
    $display("op async reset at cycle 15 of mul -> result=%h ready=%b", result, ready);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(F_MUL, 32'd3, 32'd4, 1'b0, lat, res);
    vectors++;
    if (res !== 32'd12) begin miscompares++; $display("FAIL post_reset_mul result: got %h want 0000000c", res); end
    vectors++;
    if (lat != W + 2) begin miscompares++; $display("FAIL post_reset_mul latency: got %0d want %0d", lat, W + 2); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulhsu_sign();
    test_div();
    test_div_special();
    test_back_to_back();
    test_kill();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide group (`muldiv_funct3_t`: mul, mulh, mulhsu, mulhu, div, divu, rem, remu). It sits beside the ALU in the execute stage. It accepts one operation at a time through a ready/start handshake and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles. It returns a one-cycle `done` pulse with a held result, and the pipeline stalls on it until `done`.

## Interface
- WIDTH, 32, operand/result width and iteration count; only 32 is used in rv32i, but the RTL must not hard-code it.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when `ready`=1
- funct3  in  3  `muldiv_funct3_t` encoding; sampled on accept
- rs1_data  in  WIDTH  operand A (multiplicand/dividend); sampled on accept
- rs2_data  in  WIDTH  operand B (multiplier/divisor); sampled on accept
- kill  in  1  synchronous abort (pipeline flush)
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; `result` valid in that cycle
- result  out  WIDTH  last completed result; held until the next accepted op completes

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE
  - `start`=1 and `kill`=0: latch funct3, latch operand sign flags, and latch magnitudes. A signed operand is made absolute; signedness follows funct3.
  - Load iteration counter = WIDTH.
  - Go to MUL for funct3[2]=0, DIV for funct3[2]=1.
  - Special cases for div/divu/rem/remu go straight to DONE, with the result computed in the accept cycle:
    - Divisor = 0: quotient = all ones; remainder = original rs1_data.
    - Signed overflow (div/rem, rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF): quotient = 0x8000_0000; remainder = 0.
- Signedness rules
  - mul, mulhu, divu, remu: both operands unsigned.
  - mulh, div, rem: both operands signed.
  - mulhsu: rs1 signed, rs2 unsigned.
- MUL
  - 2·WIDTH-bit accumulator. Each cycle: if multiplier LSB = 1, add multiplicand into the upper half. Then shift the {carry, accumulator} right 1, shifting the multiplier right 1.
  - Counter decrements each cycle; leave for FIX when it reaches 0 (exactly WIDTH cycles).
- DIV
  - Restoring division. Each cycle: shift {rem, quot} left 1. Trial = rem − divisor (WIDTH+1 bits). If trial is non-negative, rem = trial and quot LSB = 1.
  - Exactly WIDTH cycles, then FIX.
- FIX (one cycle)
  - Product: negate the 2·WIDTH product iff the operand signs differ. mul selects the low WIDTH bits; mulh, mulhsu and mulhu select the high WIDTH bits.
  - Quotient: negate iff the dividend and divisor signs differ.
  - Remainder: negate iff the dividend was negative.
  - Register the selected value into `result`, then go to DONE.
- DONE
  - `done`=1 for this one cycle only; go to IDLE next cycle.
  - `ready`=0 in DONE, so back-to-back ops are separated by at least one IDLE cycle.
- kill
  - In any non-IDLE state, next state = IDLE. No `done` is produced and `result` is unchanged.
  - In IDLE, kill blocks acceptance: kill and start in the same cycle means nothing is accepted.
  - kill in DONE: `done` still pulses that cycle, because it is already registered.
- start while `ready`=0 is ignored; it is not queued.
- Operand inputs may change freely after the accept cycle.

## Timing
- Reset (async assert, any state): state = IDLE, `ready`=1, `done`=0, `result`=0, counter = 0, internal registers = 0. Deassertion is synchronized to clk by the top level.
- Latency is measured from the accept edge (cycle 0) to the `done` cycle:
  - mul/div normal path: cycles 1..WIDTH in MUL/DIV, cycle WIDTH+1 in FIX, `done` in cycle WIDTH+2 (34 for WIDTH=32).
  - Special div cases: `done` in cycle 1.
- `ready` returns high in the cycle after `done`, so maximum throughput is one op per WIDTH+3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- mul 7 × −3 (rs1=7, rs2=0xFFFF_FFFD) → `done` exactly 34 cycles after accept, result 0xFFFF_FFEB. Then mulh on the same operands → 0xFFFF_FFFF; mulhu → 0x0000_0006.
- mulhsu, rs1=0xFFFF_FFFF (−1), rs2=0xFFFF_FFFF (unsigned) → result 0xFFFF_FFFF. Then mulh 0x8000_0000 × 0x8000_0000 → 0x4000_0000.
- div −7/2 → 0xFFFF_FFFD; rem −7/2 → 0xFFFF_FFFF; divu 0xFFFF_FFF9/2 → 0x7FFF_FFFC; remu the same operands → 1. Each `done` arrives at cycle 34.
- Divide by zero: div 5/0 → 0xFFFF_FFFF; rem 5/0 → 5. Overflow: div 0x8000_0000 / −1 → 0x8000_0000; rem → 0. Each `done` arrives at cycle 1.
- kill asserted at cycle 10 of a div → IDLE and `ready`=1 next cycle; no `done`; `result` keeps its prior value. start with kill in IDLE → not accepted. start during busy → ignored.
- rst pulled low mid-MUL (cycle 15) → `ready`=1, `done`=0, `result`=0 immediately. After release, a fresh mul 3×4 → 12 at cycle 34.
